// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding, mux select constants and datapath width for the GCD controller
package gcd_pkg;
  localparam int DATA_WID = 8;
  localparam logic SEL_A   = 1'b0;
  localparam logic SEL_B   = 1'b1;
  localparam logic SEL_DIN = 1'b1;
  localparam logic SEL_SUB = 1'b0;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } gcd_state_t;
endpackage

// File: rtl/gcd_iter_cnt.sv
// gcd_iter_cnt: saturating subtraction counter with synchronous clear and a limit-hit flag
module gcd_iter_cnt #(
  parameter int W     = 9,
  parameter int LIMIT = 256
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_hit
);
  logic [W-1:0] r_cnt;
  // clear wins over increment; the count sticks at all-ones instead of wrapping
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  assign o_cnt = r_cnt;
  assign o_hit = (r_cnt == W'(LIMIT));
endmodule

// File: rtl/gcd_ctrl.sv
// gcd_ctrl: handshake + compare/subtract sequencer for the GCD datapath; GCD_TIMEOUT_EN enables the MAX_ITER abort
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int ITER_W   = 9,
  parameter int MAX_ITER = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_op_valid,
  output logic              o_op_ready,
  input  logic              i_eq,
  input  logic              i_lt,
  input  logic              i_gt,
  output logic              o_load_a,
  output logic              o_load_b,
  output logic              o_sel1,
  output logic              o_sel2,
  output logic              o_sel3,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ITER_W-1:0] o_iter
);
`ifdef GCD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  gcd_state_t r_state;
  logic w_run, w_onehot, w_hit, w_to, w_err, w_sub, w_clr;
  assign w_run    = (r_state == RUN);
  assign w_onehot = ({1'b0, i_eq} + {1'b0, i_lt} + {1'b0, i_gt}) == 2'd1;
  assign w_to     = TO_EN && w_hit && !i_eq;
  assign w_err    = !w_onehot || w_to;
  assign w_sub    = w_run && !w_err && !i_eq;
  assign w_clr    = (r_state == IDLE || r_state == ERR) && i_start;
  gcd_iter_cnt #(.W(ITER_W), .LIMIT(MAX_ITER)) u_cnt (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (w_clr),
    .i_inc  (w_sub),
    .o_cnt  (o_iter),
    .o_hit  (w_hit)
  );
  // state sequencing; RUN exits on EQ, on malformed flags, or on timeout
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else case (r_state)
      IDLE, ERR: if (i_start) r_state <= LOAD_A;
      LOAD_A:    if (i_op_valid) r_state <= LOAD_B;
      LOAD_B:    if (i_op_valid) r_state <= RUN;
      RUN:       r_state <= w_err ? ERR : i_eq ? DONE : RUN;
      DONE:      r_state <= IDLE;
      default:   r_state <= IDLE;
    endcase
  // loads and selects are Mealy on valid/flags so a transfer or subtraction lands every cycle
  always_comb begin
    o_op_ready = (r_state == LOAD_A) || (r_state == LOAD_B);
    o_sel3     = o_op_ready ? SEL_DIN : SEL_SUB;
    o_load_a   = ((r_state == LOAD_A) && i_op_valid) || (w_sub && i_gt);
    o_load_b   = ((r_state == LOAD_B) && i_op_valid) || (w_sub && i_lt);
    o_sel1     = (w_sub && i_lt) ? SEL_B : SEL_A;
    o_sel2     = (w_sub && i_gt) ? SEL_B : SEL_A;
    o_busy     = o_op_ready || w_run;
    o_done     = (r_state == DONE);
    o_err      = (r_state == ERR);
  end
endmodule

// File: tb/tb_gcd_ctrl.sv
// tb_gcd_ctrl: directed test of gcd_ctrl driving a behavioural 8-bit subtract/compare datapath
module tb_gcd_ctrl;
  logic       i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_op_valid = 1'b0;
  logic       o_op_ready, o_load_a, o_load_b, o_sel1, o_sel2, o_sel3, o_busy, o_done, o_err;
  logic       i_eq, i_lt, i_gt;
  logic [8:0] o_iter;
  logic [7:0] din = 8'd0, dp_a, dp_b, sub;
  logic       frc = 1'b0, frc_eq = 1'b0, frc_lt = 1'b0, frc_gt = 1'b0;
  int         n_chk = 0, n_err = 0, n;

  always #5 i_clk = ~i_clk;

  gcd_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op_valid(i_op_valid),
    .o_op_ready(o_op_ready), .i_eq(i_eq), .i_lt(i_lt), .i_gt(i_gt),
    .o_load_a(o_load_a), .o_load_b(o_load_b), .o_sel1(o_sel1), .o_sel2(o_sel2),
    .o_sel3(o_sel3), .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_iter(o_iter)
  );

  assign sub  = (o_sel1 ? dp_b : dp_a) - (o_sel2 ? dp_b : dp_a);
  assign i_eq = frc ? frc_eq : (dp_a == dp_b);
  assign i_lt = frc ? frc_lt : (dp_a < dp_b);
  assign i_gt = frc ? frc_gt : (dp_a > dp_b);

  // behavioural datapath registers A/B behind the input mux
  always_ff @(posedge i_clk) begin
    if (o_load_a) dp_a <= o_sel3 ? din : sub;
    if (o_load_b) dp_b <= o_sel3 ? din : sub;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #2;
  endtask

  task automatic do_start;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic load_ops(input logic [7:0] x, input logic [7:0] y);
    i_op_valid = 1'b1;
    din = x;
    tick();
    din = y;
    tick();
    i_op_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!o_done && cyc < 600) begin
      tick();
      cyc++;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_out"}, {o_op_ready, o_load_a, o_load_b, o_sel1, o_sel2, o_sel3, o_busy, o_done, o_err}, 0);
    chk({tag, "_iter"}, o_iter, 0);
  endtask

  task automatic pulse_reset;
    #1 i_rst_n = 1'b0;
    #3 i_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #12;
    chk_idle("reset");
    i_rst_n = 1'b1;
    tick();

    do_start();
    i_op_valid = 1'b1;
    din = 8'd12;
    #1;
    chk("la_strobes", {o_op_ready, o_sel3, o_load_a, o_load_b, o_busy}, 5'b11101);
    tick();
    din = 8'd8;
    #1;
    chk("lb_strobes", {o_op_ready, o_sel3, o_load_a, o_load_b}, 4'b1101);
    tick();
    i_op_valid = 1'b0;
    chk("run_gt", {o_load_a, o_load_b, o_sel1, o_sel2, o_sel3, o_op_ready}, 6'b100100);
    tick();
    chk("run_lt", {o_load_a, o_load_b, o_sel1, o_sel2, o_sel3}, 5'b01100);
    chk("iter_1", o_iter, 1);
    tick();
    chk("run_eq", {o_load_a, o_load_b, o_done, o_busy}, 4'b0001);
    tick();
    chk("done_12_8", o_done, 1);
    chk("a_12_8", dp_a, 4);
    chk("iter_12_8", o_iter, 2);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("start_in_done", {o_busy, o_done, o_op_ready}, 0);
    chk("iter_hold", o_iter, 2);

    do_start();
    load_ops(8'd9, 8'd9);
    wait_done(n);
    chk("lat_9_9", n, 2);
    chk("a_9_9", dp_a, 9);
    chk("iter_9_9", o_iter, 0);
    tick();

    do_start();
    load_ops(8'd0, 8'd0);
    wait_done(n);
    chk("lat_0_0", n, 2);
    chk("a_0_0", dp_a, 0);
    tick();

    do_start();
    repeat (3) begin
      chk("wait_ready", {o_op_ready, o_load_a, o_busy}, 3'b101);
      tick();
    end
    load_ops(8'd255, 8'd1);
    wait_done(n);
    chk("lat_255_1", n, 256);
    chk("a_255_1", dp_a, 1);
    chk("iter_255_1", o_iter, 254);
    chk("err_255_1", o_err, 0);
    tick();

    do_start();
    load_ops(8'd200, 8'd6);
    tick();
    tick();
    chk("pre_rst_iter", o_iter, 2);
    #1 i_rst_n = 1'b0;
    #1;
    chk_idle("rst_async");
    tick();
    chk_idle("rst_held");
    #1 i_rst_n = 1'b1;
    tick();

    do_start();
    load_ops(8'd7, 8'd3);
    tick();
    frc = 1'b1;
    frc_gt = 1'b1;
    frc_lt = 1'b1;
    #1;
    chk("bad_flags_loads", {o_load_a, o_load_b}, 0);
    tick();
    frc = 1'b0;
    frc_gt = 1'b0;
    frc_lt = 1'b0;
    chk("bad_flags_err", {o_err, o_busy}, 2'b10);
    chk("err_iter_hold", o_iter, 1);
    tick();
    chk("err_holds", o_err, 1);
    do_start();
    chk("err_restart", {o_busy, o_op_ready, o_err}, 3'b110);
    chk("err_restart_iter", o_iter, 0);
    pulse_reset();

    do_start();
    load_ops(8'd0, 8'd5);
`ifdef GCD_TIMEOUT_EN
    n = 0;
    while (!o_err && n < 600) begin
      tick();
      n++;
    end
    chk("to_err", o_err, 1);
    chk("to_iter", o_iter, 256);
    do_start();
    chk("to_restart", {o_busy, o_err}, 2'b10);
    chk("to_restart_iter", o_iter, 0);
`else
    repeat (520) tick();
    chk("hang_busy", {o_busy, o_err, o_done}, 3'b100);
    chk("iter_sat", o_iter, 511);
`endif
    pulse_reset();
    chk_idle("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
